// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-core data memory with a four-phase host port; define CONFLICT_DETECT_EN for a registered same-address-write conflict pulse
module data_mem_responder #(
  parameter int REG_WIDTH = 12,
  parameter int DEPTH     = 256,
  parameter int CORES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       runEn,
  input  logic [CORES*REG_WIDTH-1:0] coreAddr,
  input  logic [CORES*REG_WIDTH-1:0] coreWrData,
  input  logic [CORES-1:0]           coreWrEn,
  output logic [CORES*REG_WIDTH-1:0] coreRdData,
  input  logic                       hostReq,
  input  logic                       hostWr,
  input  logic [REG_WIDTH-1:0]       hostAddr,
  input  logic [REG_WIDTH-1:0]       hostWrData,
  output logic                       hostAck,
  output logic [REG_WIDTH-1:0]       hostRdData,
  output logic                       conflict
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [REG_WIDTH:0] LIM = (REG_WIDTH+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2, WAIT_DROP = 2'd3;
  logic [REG_WIDTH-1:0] mem [DEPTH];
  logic [1:0]           r_state;
  logic                 r_wr;
  logic [REG_WIDTH-1:0] r_addr, r_wdata;
  logic [REG_WIDTH-1:0] w_addr [CORES];
  logic [REG_WIDTH-1:0] w_wdata [CORES];
  logic [CORES-1:0]     w_in, w_we;
  logic                 w_core_ok, w_host_in;
  genvar g;
  generate
    for (g = 0; g < CORES; g++) begin : g_core
      assign w_addr[g]  = coreAddr[g*REG_WIDTH +: REG_WIDTH];
      assign w_wdata[g] = coreWrData[g*REG_WIDTH +: REG_WIDTH];
      assign w_in[g]    = {1'b0, w_addr[g]} < LIM;
    end
  endgenerate
  assign w_core_ok = runEn && !rst && (r_state == IDLE || r_state == WAIT_DROP);
  assign w_we      = coreWrEn & w_in & {CORES{w_core_ok}};
  assign w_host_in = {1'b0, r_addr} < LIM;
  always_ff @(posedge clk) begin
    for (int i = CORES - 1; i >= 0; i--)
      if (w_we[i]) mem[w_addr[i][AW-1:0]] <= w_wdata[i];
    if (!rst && r_state == ACCESS && r_wr && w_host_in) mem[r_addr[AW-1:0]] <= r_wdata;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < CORES; i++)
      coreRdData[i*REG_WIDTH +: REG_WIDTH] <= (rst || !w_in[i]) ? '0 : mem[w_addr[i][AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      hostAck    <= 1'b0;
      hostRdData <= '0;
    end else begin
      hostAck    <= r_state == ACCESS;
      hostRdData <= (r_state == ACCESS && !r_wr && w_host_in) ? mem[r_addr[AW-1:0]] : '0;
      if (r_state == IDLE && hostReq && !runEn) begin
        r_wr    <= hostWr;
        r_addr  <= hostAddr;
        r_wdata <= hostWrData;
      end
      r_state <= r_state == IDLE   ? ((hostReq && !runEn) ? ACCESS : IDLE) :
                 r_state == ACCESS ? ACK :
                 r_state == ACK    ? WAIT_DROP :
                 (hostReq ? WAIT_DROP : IDLE);
    end
  end
`ifdef CONFLICT_DETECT_EN
  logic w_conf;
  always_comb begin
    w_conf = 1'b0;
    for (int i = 0; i < CORES; i++)
      for (int j = i + 1; j < CORES; j++)
        w_conf = w_conf | (w_we[i] && w_we[j] && w_addr[i] == w_addr[j]);
  end
  always_ff @(posedge clk) conflict <= !rst && w_conf;
`else
  assign conflict = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven and directed checks of data_mem_responder
module tb_data_mem_responder;
  logic        clk = 1'b0, rst = 1'b1, runEn = 1'b0;
  logic [47:0] coreAddr = '0, coreWrData = '0, coreRdData;
  logic [3:0]  coreWrEn = '0;
  logic        hostReq = 1'b0, hostWr = 1'b0, hostAck, conflict;
  logic [11:0] hostAddr = '0, hostWrData = '0, hostRdData;
  int n_vec = 0, n_err = 0;
`ifdef CONFLICT_DETECT_EN
  localparam bit CF = 1'b1;
`else
  localparam bit CF = 1'b0;
`endif
  typedef struct {
    logic        run;
    logic [47:0] addr;
    logic [47:0] wd;
    logic [3:0]  we;
    logic [3:0]  msk;
    logic [47:0] exp;
    logic        cf;
  } vec_t;
  vec_t tbl [13];
  data_mem_responder dut (
    .clk(clk), .rst(rst), .runEn(runEn),
    .coreAddr(coreAddr), .coreWrData(coreWrData), .coreWrEn(coreWrEn), .coreRdData(coreRdData),
    .hostReq(hostReq), .hostWr(hostWr), .hostAddr(hostAddr), .hostWrData(hostWrData),
    .hostAck(hostAck), .hostRdData(hostRdData), .conflict(conflict)
  );
  always #5 clk = ~clk;
  function automatic logic [47:0] pk(input logic [11:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic host_access(input logic wr, input logic [11:0] a, input logic [11:0] d, output logic [11:0] rd);
    logic got;
    got = 1'b0;
    rd  = 'x;
    @(negedge clk);
    hostReq = 1'b1; hostWr = wr; hostAddr = a; hostWrData = d;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (hostAck) begin
        got = 1'b1;
        rd  = hostRdData;
      end
    end
    chk("host_ack_seen", 48'(got), 48'd1);
    @(posedge clk); #1;
    chk("host_ack_one_cycle", 48'(hostAck), 48'd0);
    @(posedge clk); #1;
    chk("host_wait_drop_no_ack", 48'(hostAck), 48'd0);
    @(negedge clk);
    hostReq = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  initial begin
    logic [11:0] rd;
    logic        got;
    int          lat;
    tbl[0]  = '{1'b1, pk(10, 11, 12, 13), pk(1, 2, 3, 4), 4'b1111, 4'b0000, '0, 1'b0};
    tbl[1]  = '{1'b1, pk(10, 11, 12, 13), '0, 4'b0000, 4'b1111, pk(1, 2, 3, 4), 1'b0};
    tbl[2]  = '{1'b1, pk(10, 20, 11, 20), pk(0, 12'h111, 0, 12'h333), 4'b1010, 4'b0101, pk(1, 0, 2, 0), CF};
    tbl[3]  = '{1'b1, pk(20, 20, 20, 20), '0, 4'b0000, 4'b1111, pk(12'h111, 12'h111, 12'h111, 12'h111), 1'b0};
    tbl[4]  = '{1'b1, pk(20, 0, 7, 44), pk(0, 0, 12'h005, 12'h044), 4'b1100, 4'b0001, pk(12'h111, 0, 0, 0), 1'b0};
    tbl[5]  = '{1'b1, pk(7, 0, 7, 30), pk(0, 0, 12'h0FF, 12'h030), 4'b1100, 4'b0101, pk(12'h005, 0, 12'h005, 0), 1'b0};
    tbl[6]  = '{1'b1, pk(7, 30, 44, 0), '0, 4'b0000, 4'b0111, pk(12'h0FF, 12'h030, 12'h044, 0), 1'b0};
    tbl[7]  = '{1'b1, pk(300, 300, 0, 0), pk(12'h0AA, 0, 0, 0), 4'b0001, 4'b0010, '0, 1'b0};
    tbl[8]  = '{1'b1, pk(44, 0, 0, 0), '0, 4'b0000, 4'b0001, pk(12'h044, 0, 0, 0), 1'b0};
    tbl[9]  = '{1'b1, pk(21, 21, 21, 10), pk(12'h0A1, 12'h0A2, 12'h0A3, 0), 4'b0111, 4'b1000, pk(0, 0, 0, 1), CF};
    tbl[10] = '{1'b1, pk(21, 10, 0, 0), '0, 4'b0000, 4'b0011, pk(12'h0A1, 1, 0, 0), 1'b0};
    tbl[11] = '{1'b0, pk(10, 11, 0, 0), pk(12'h777, 0, 0, 0), 4'b0001, 4'b0010, pk(0, 2, 0, 0), 1'b0};
    tbl[12] = '{1'b1, pk(10, 0, 0, 0), '0, 4'b0000, 4'b0001, pk(1, 0, 0, 0), 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hostAck", 48'(hostAck), 48'd0);
    chk("rst_hostRdData", 48'(hostRdData), 48'd0);
    chk("rst_coreRdData", coreRdData, 48'd0);
    chk("rst_conflict", 48'(conflict), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      runEn = tbl[v].run; coreAddr = tbl[v].addr; coreWrData = tbl[v].wd; coreWrEn = tbl[v].we;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++)
        if (tbl[v].msk[c]) chk($sformatf("v%0d_core%0d", v, c), 48'(coreRdData[c*12 +: 12]), 48'(tbl[v].exp[c*12 +: 12]));
      chk($sformatf("v%0d_conflict", v), 48'(conflict), 48'(tbl[v].cf));
    end
    @(negedge clk);
    runEn = 1'b0; coreWrEn = '0; coreAddr = '0;
    host_access(1'b1, 12'd5, 12'hABC, rd);
    chk("host_write_rddata", 48'(rd), 48'd0);
    host_access(1'b0, 12'd5, 12'h000, rd);
    chk("host_read_5", 48'(rd), 48'hABC);
    @(negedge clk);
    runEn = 1'b1; hostReq = 1'b1; hostWr = 1'b0; hostAddr = 12'd300;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("blocked_ack_%0d", k), 48'(hostAck), 48'd0);
    end
    @(negedge clk);
    runEn = 1'b0;
    got = 1'b0; lat = 0; rd = 'x;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (hostAck) begin
        got = 1'b1;
        rd  = hostRdData;
      end
    end
    chk("late_ack_seen", 48'(got), 48'd1);
    chk("late_ack_within_3", 48'(lat <= 3), 48'd1);
    chk("host_read_oob", 48'(rd), 48'd0);
    @(negedge clk);
    hostReq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    hostReq = 1'b1; hostWr = 1'b1; hostAddr = 12'd30; hostWrData = 12'hDEA;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_access_ack", 48'(hostAck), 48'd0);
    @(negedge clk);
    rst = 1'b0; hostReq = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abandoned_ack_%0d", k), 48'(hostAck), 48'd0);
    end
    @(negedge clk);
    coreAddr = pk(30, 0, 0, 0);
    @(posedge clk); #1;
    chk("mem30_unchanged", 48'(coreRdData[11:0]), 48'h030);
    @(negedge clk);
    hostReq = 1'b1; hostWr = 1'b1; hostAddr = 12'd31; hostWrData = 12'h131;
    @(posedge clk);
    @(negedge clk);
    runEn = 1'b1; coreAddr = pk(31, 0, 0, 0); coreWrData = pk(12'h999, 0, 0, 0); coreWrEn = 4'b0001;
    @(posedge clk); #1;
    chk("access_runen_ack", 48'(hostAck), 48'd1);
    @(negedge clk);
    coreWrEn = '0; hostReq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mem31_host_wins", 48'(coreRdData[11:0]), 48'h131);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
